// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit between execute and writeback.
// It talks to a registered-read word memory and does byte stores as read-modify-write.
module mem_stage_lsu #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [3:0]        resp_rd,
    output logic              resp_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_rdData
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
    state_t state;
    logic [DATA_W-1:0] addrQ, wdataQ, respData, wrData, loadVal, mergeVal;
    logic [7:0] lane;
    logic [3:0] rdQ;
    logic writeQ, byteQ, signedQ, respErr;
    always_comb begin
        lane     = addrQ[0] ? mem_rdData[15:8] : mem_rdData[7:0];
        loadVal  = byteQ ? {{8{signedQ & lane[7]}}, lane} : mem_rdData;
        mergeVal = addrQ[0] ? {wdataQ[7:0], mem_rdData[7:0]} : {mem_rdData[15:8], wdataQ[7:0]};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addrQ    <= '0;
            wdataQ   <= '0;
            respData <= '0;
            wrData   <= '0;
            rdQ      <= '0;
            writeQ   <= 1'b0;
            byteQ    <= 1'b0;
            signedQ  <= 1'b0;
            respErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addrQ    <= req_addr;
                    wdataQ   <= req_wdata;
                    writeQ   <= req_write;
                    byteQ    <= req_byte;
                    signedQ  <= req_signed;
                    rdQ      <= req_rd;
                    wrData   <= req_wdata;
                    respData <= '0;
                    respErr  <= !req_byte && req_addr[0];
                    // misaligned words skip memory entirely; byte stores need the old word first
                    state    <= (!req_byte && req_addr[0]) ? RESP : (req_write && !req_byte) ? WR : RD;
                end
                RD: state <= CAP;
                CAP: begin
                    if (writeQ) wrData <= mergeVal;
                    else respData <= loadVal;
                    state <= writeQ ? WR : RESP;
                end
                WR: state <= RESP;
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign req_ready    = state == IDLE;
    assign resp_valid   = state == RESP;
    assign mem_memRead  = state == RD;
    assign mem_memWrite = state == WR;
    assign mem_addr     = {1'b0, addrQ[DATA_W-1:1]};
    assign mem_wrData   = wrData;
    assign resp_data    = respData;
    assign resp_err     = respErr;
    assign resp_rd      = rdQ;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vector table, reset/stall sequences and a random run
// checked against a byte-addressed memory model.
module tb_mem_stage_lsu;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_write = 0, req_byte = 0, req_signed = 0, resp_ready = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic [3:0] req_rd = 0;
    logic req_ready, resp_valid, resp_err, mem_memRead, mem_memWrite;
    logic [15:0] resp_data, mem_addr, mem_wrData;
    logic [3:0] resp_rd;
    logic [15:0] rdData = 0, lastWr = 0;
    logic [15:0] mem [0:1023];
    logic [7:0] refBytes [0:127];
    int total = 0, bad = 0, nReads = 0, nWrites = 0;

    typedef struct {
        logic w, b, s;
        logic [15:0] a, wd;
        logic [3:0] rd;
        logic [15:0] expData;
        logic expErr;
        int expLat;
        logic [15:0] expWr;
        int hold;
    } vec_t;
    vec_t vecs [0:13];

    mem_stage_lsu #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_wrData(mem_wrData), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_rdData(rdData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memWrite) begin
            mem[mem_addr[9:0]] <= mem_wrData;
            nWrites++;
            lastWr = mem_wrData;
        end
        if (mem_memRead) begin
            rdData <= mem[mem_addr[9:0]];
            nReads++;
        end
    end

    always @(negedge clk)
        if (mem_memRead && mem_memWrite) begin
            total++;
            bad++;
            $display("FAIL rd_wr_overlap: memRead=%b memWrite=%b want not both", mem_memRead, mem_memWrite);
        end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic runTxn(input logic w, input logic b, input logic s, input logic [15:0] a,
                          input logic [15:0] wd, input logic [3:0] rd, input int hold,
                          output logic [15:0] gd, output logic ge, output logic [3:0] gr,
                          output int lat);
        logic [22:0] snap;
        @(negedge clk);
        req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1; resp_ready = 0;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0; nReads = 0; nWrites = 0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        gd = resp_data; ge = resp_err; gr = resp_rd;
        snap = {resp_valid, req_ready, ge, gr, gd};
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_stable", {resp_valid, req_ready, resp_err, resp_rd, resp_data}, {1'b1, 1'b0, snap[20:0]});
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        check("resp_exit", {resp_valid, req_ready}, 2'b01);
    endtask

    logic [15:0] gd, wd, a, eData;
    logic ge, w, b, s, err;
    logic [3:0] gr, rd;
    int lat, eLat, v;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[8] = 16'hCAFE;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hBABA, 4'd1,  16'h0000, 1'b0, 2, 16'hBABA, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd2,  16'hBABA, 1'b0, 3, 16'h0000, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h1EAF, 4'd3,  16'h0000, 1'b0, 2, 16'h1EAF, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h0055, 4'd4,  16'h0000, 1'b0, 4, 16'h55AF, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 4'd5,  16'h55AF, 1'b0, 3, 16'h0000, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 4'd6,  16'hFFAF, 1'b0, 3, 16'h0000, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 4'd7,  16'h00AF, 1'b0, 3, 16'h0000, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 4'd8,  16'h0000, 1'b1, 1, 16'h0000, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000, 4'd9,  16'h0055, 1'b0, 3, 16'h0000, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h1280, 4'd10, 16'h0000, 1'b0, 4, 16'h5580, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 4'd11, 16'hFF80, 1'b0, 3, 16'h0000, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'hFFFF, 4'd12, 16'h0000, 1'b1, 1, 16'h0000, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 4'd13, 16'h5580, 1'b0, 3, 16'h0000, 5};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd14, 16'hBABA, 1'b0, 3, 16'h0000, 0};

        #1 rst = 0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_outs", {resp_valid, resp_err, mem_memRead, mem_memWrite}, 4'b0000);
        check("rst_fields", {resp_data, resp_rd}, 20'h0);
        check("rst_mem_bus", {mem_addr, mem_wrData}, 32'h0);
        @(negedge clk) rst = 1;

        for (int i = 0; i < 14; i++) begin
            runTxn(vecs[i].w, vecs[i].b, vecs[i].s, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].hold, gd, ge, gr, lat);
            check($sformatf("v%0d_data", i), gd, vecs[i].expData);
            check($sformatf("v%0d_err", i), ge, vecs[i].expErr);
            check($sformatf("v%0d_rd", i), gr, vecs[i].rd);
            check($sformatf("v%0d_lat", i), lat, vecs[i].expLat);
            check($sformatf("v%0d_reads", i), nReads, (!vecs[i].expErr && (!vecs[i].w || vecs[i].b)) ? 1 : 0);
            check($sformatf("v%0d_writes", i), nWrites, (!vecs[i].expErr && vecs[i].w) ? 1 : 0);
            if (!vecs[i].expErr && vecs[i].w) check($sformatf("v%0d_wrdata", i), lastWr, vecs[i].expWr);
        end

        // reset in the middle of a word store must kill the write outright
        @(negedge clk);
        req_write = 1; req_byte = 0; req_addr = 16'h0010; req_wdata = 16'h1234; req_rd = 4'hA; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; nWrites = 0;
        check("rst_wr_active", mem_memWrite, 1);
        #2 rst = 0;
        #1;
        check("rst_async_wr", mem_memWrite, 0);
        check("rst_async_ready", req_ready, 1);
        check("rst_async_valid", resp_valid, 0);
        check("rst_async_bus", {mem_addr, mem_wrData}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_kept", mem[8], 16'hCAFE);
        check("rst_no_write", nWrites, 0);
        check("rst_release_ready", req_ready, 1);

        for (int i = 0; i < 64; i++) begin
            refBytes[2*i] = mem[i][7:0];
            refBytes[2*i+1] = mem[i][15:8];
        end
        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 127)); wd = 16'($urandom); rd = 4'($urandom);
            err = !b && a[0];
            eData = 16'h0;
            if (err) eLat = 1;
            else if (w) eLat = b ? 4 : 2;
            else begin
                eLat = 3;
                if (b) begin
                    v = int'(refBytes[a]);
                    if (s && v >= 128) v = v - 256;
                    eData = v[15:0];
                end else eData = {refBytes[a+1], refBytes[a]};
            end
            runTxn(w, b, s, a, wd, rd, $urandom_range(0, 2), gd, ge, gr, lat);
            check("rnd_data", gd, eData);
            check("rnd_err", ge, err);
            check("rnd_rd", gr, rd);
            check("rnd_lat", lat, eLat);
            check("rnd_reads", nReads, (!err && (!w || b)) ? 1 : 0);
            check("rnd_writes", nWrites, (!err && w) ? 1 : 0);
            if (!err && w) begin
                refBytes[a] = wd[7:0];
                if (!b) refBytes[a+1] = wd[15:8];
            end
        end
        for (int i = 0; i < 64; i++) check($sformatf("mem_final_%0d", i), mem[i], {refBytes[2*i+1], refBytes[2*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
